// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first WIDTH-bit subtractor (DIFF = A - B)
// built from one full-subtractor cell and a borrow flip-flop. A START/BUSY/DONE
// handshake sequences one operation per WIDTH+1 clocks when issued back to back.
module serial_subtractor #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bor;
  logic             r_borrow;

  logic w_a0;
  logic w_b0;
  logic w_d;
  logic w_bor_next;
  logic w_accept;
  logic w_last;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign w_a0       = r_a_sh[0];
  assign w_b0       = r_b_sh[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_bor;
  assign w_bor_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bor);

  // START is honoured only from IDLE or DONE; it is ignored mid-shift.
  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_SHIFT;
      S_SHIFT: if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = i_start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand load, serial shift, and result capture on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: every datapath register is reset so an aborted operation leaves
    // no stale result or borrow visible.
    if (!i_rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_cnt    <= '0;
      r_bor    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= i_a;
      r_b_sh <= i_b;
      r_cnt  <= '0;
      r_bor  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_r_sh <= {w_d, r_r_sh[WIDTH-1:1]};
      r_bor  <= w_bor_next;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= {w_d, r_r_sh[WIDTH-1:1]};
        r_borrow <= w_bor_next;
      end
    end
  end

  assign o_busy   = (r_state == S_SHIFT);
  assign o_done   = (r_state == S_DONE);
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;

endmodule
